// File: rtl/btn_debounce_mode_pkg.sv
// btn_debounce_mode_pkg: shared button FSM encoding and debounce sizing helpers
package btn_debounce_mode_pkg;
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } btn_state_t;
  function automatic int db_cnt(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_debounce_mode_sync_debounce.sv
// btn_debounce_mode_sync_debounce: 2-flop synchronizer plus stable-time level debounce
module btn_debounce_mode_sync_debounce #(
  parameter int DB = 4,
  parameter int CW = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level
);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic done;
  assign done = sync[1] != level && cnt == CW'(DB - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      cnt   <= (sync[1] == level || done) ? '0 : cnt + CW'(1);
      level <= done ? sync[1] : level;
    end
endmodule

// File: rtl/btn_debounce_mode.sv
// btn_debounce_mode: debounced button/switch with press-stepped wrapping mode register
module btn_debounce_mode
  import btn_debounce_mode_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int NUM_MODES   = 4,
  parameter int MODE_W      = 2
) (
  input  logic              clk50M,
  input  logic              reset,
  input  logic              btn_raw,
  input  logic              sw_raw,
  output logic              btn_level,
  output logic              btn_press,
  output logic              btn_release,
  output logic              sw_level,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed
);
  localparam int DB = db_cnt(CLK_HZ, DEBOUNCE_MS);
  localparam int CW = cnt_w(DB);
  localparam logic [MODE_W-1:0] MAXM = MODE_W'(NUM_MODES - 1);
  btn_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] btn_sync;
  logic press_nxt, release_nxt, last;
  logic [MODE_W-1:0] mode_nxt;
  btn_debounce_mode_sync_debounce #(.DB(DB), .CW(CW)) u_sw (
    .clk  (clk50M),
    .rst_n(reset),
    .din  (sw_raw),
    .level(sw_level)
  );
  assign last      = cnt == CW'(DB - 2);
  assign btn_level = state == PRESSED || state == CHK_RELEASE;
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE:        state_nxt = btn_sync[1] ? CHK_PRESS : IDLE;
      CHK_PRESS:   if (!btn_sync[1]) state_nxt = IDLE;
                   else if (last) begin
                     state_nxt = PRESSED;
                     press_nxt = 1'b1;
                   end else cnt_nxt = cnt + CW'(1);
      PRESSED:     state_nxt = btn_sync[1] ? PRESSED : CHK_RELEASE;
      CHK_RELEASE: if (btn_sync[1]) state_nxt = PRESSED;
                   else if (last) begin
                     state_nxt   = IDLE;
                     release_nxt = 1'b1;
                   end else cnt_nxt = cnt + CW'(1);
      default:     state_nxt = IDLE;
    endcase
    mode_nxt = sw_level ? ((mode == '0) ? MAXM : mode - MODE_W'(1))
                        : ((mode == MAXM) ? '0 : mode + MODE_W'(1));
  end
  always_ff @(posedge clk50M or negedge reset)
    if (!reset) begin
      btn_sync     <= '0;
      state        <= IDLE;
      cnt          <= '0;
      btn_press    <= 1'b0;
      btn_release  <= 1'b0;
      mode         <= '0;
      mode_changed <= 1'b0;
    end else begin
      btn_sync     <= {btn_sync[0], btn_raw};
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      btn_press    <= press_nxt;
      btn_release  <= release_nxt;
      mode         <= press_nxt ? mode_nxt : mode;
      mode_changed <= press_nxt;
    end
endmodule

// File: tb/tb_btn_debounce_mode.sv
// tb_btn_debounce_mode: vector table plus directed sequences for btn_debounce_mode
module tb_btn_debounce_mode;
  logic clk50M = 1'b0;
  logic reset, btn_raw, sw_raw;
  logic btn_level, btn_press, btn_release, sw_level, mode_changed;
  logic [1:0] mode;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic       btn;
    logic       sw;
    logic [6:0] exp;
  } vec_t;
  vec_t tv[$];
  btn_debounce_mode #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .NUM_MODES(4), .MODE_W(2)) dut (
    .clk50M      (clk50M),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .sw_raw      (sw_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .sw_level    (sw_level),
    .mode        (mode),
    .mode_changed(mode_changed)
  );
  always #5 clk50M = ~clk50M;
  function automatic logic [6:0] obs();
    return {btn_level, btn_press, btn_release, sw_level, mode, mode_changed};
  endfunction
  function automatic void add(input logic b, input logic s, input logic lvl, input logic pr,
                              input logic rl, input logic swl, input logic [1:0] m,
                              input logic mc, input int n);
    for (int i = 0; i < n; i++) tv.push_back('{b, s, {lvl, pr, rl, swl, m, mc}});
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk50M);
    #1;
  endtask
  task automatic do_press(input int exp_mode);
    int at = 0;
    int n = 0;
    for (int i = 1; i <= 8; i++) begin
      btn_raw = 1'b1;
      cyc();
      if (btn_press) begin
        n++;
        at = i;
        chk("press_mc", int'(mode_changed), 1);
      end
    end
    chk("press_lat", at, 6);
    chk("press_cnt", n, 1);
    chk("press_mode", int'(mode), exp_mode);
    btn_raw = 1'b0;
    repeat (8) cyc();
    chk("press_rel_lvl", int'(btn_level), 0);
  endtask
  initial begin
    reset = 1'b0;
    btn_raw = 1'b1;
    sw_raw = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("in_reset%0d", i), int'(obs()), 0);
    end
    reset = 1'b1;
    add(1, 1, 0, 0, 0, 0, 0, 0, 5);
    add(1, 1, 1, 1, 0, 1, 1, 1, 1);
    add(1, 1, 1, 0, 0, 1, 1, 0, 3);
    add(0, 0, 1, 0, 0, 1, 1, 0, 5);
    add(0, 0, 0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(1, 0, 0, 0, 0, 0, 1, 0, 5);
    add(1, 0, 1, 1, 0, 0, 2, 1, 1);
    add(1, 0, 1, 0, 0, 0, 2, 0, 14);
    add(0, 0, 1, 0, 0, 0, 2, 0, 5);
    add(0, 0, 0, 0, 1, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 2);
    add(1, 0, 0, 0, 0, 0, 2, 0, 3);
    add(0, 0, 0, 0, 0, 0, 2, 0, 2);
    add(1, 0, 0, 0, 0, 0, 2, 0, 5);
    add(1, 0, 1, 1, 0, 0, 3, 1, 1);
    add(1, 0, 1, 0, 0, 0, 3, 0, 4);
    add(0, 0, 1, 0, 0, 0, 3, 0, 5);
    add(0, 0, 0, 0, 1, 0, 3, 0, 1);
    add(0, 0, 0, 0, 0, 0, 3, 0, 2);
    foreach (tv[i]) begin
      btn_raw = tv[i].btn;
      sw_raw = tv[i].sw;
      cyc();
      chk($sformatf("vec%0d", i), int'(obs()), int'(tv[i].exp));
    end
    btn_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("mid_press%0d", i), int'(btn_press), 0);
    end
    #1 reset = 1'b0;
    #1 chk("async_clear", int'(obs()), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("held_reset%0d", i), int'(obs()), 0);
    end
    btn_raw = 1'b0;
    reset = 1'b1;
    repeat (3) cyc();
    chk("post_reset_idle", int'(obs()), 0);
    do_press(1);
    do_press(2);
    do_press(3);
    do_press(0);
    sw_raw = 1'b1;
    repeat (8) cyc();
    chk("sw_up", int'(sw_level), 1);
    do_press(3);
    do_press(2);
    do_press(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
  always @(negedge clk50M)
    if (btn_press && btn_release) begin
      failures++;
      $display("FAIL press_and_release actual=1 required=0");
    end
endmodule
